// File: rtl/instr_stream_player.sv
// Instruction-stream player: buffers a program loaded word by word, then
// plays it out under a valid/ready handshake in single-pass or loop mode.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | not playing; loads, clears and start accepted; NOP driven
//   S_PLAY | presenting mem[rd_ptr] with instr_valid=1
//   S_DONE | program finished; same as S_IDLE except done on first cycle
module instr_stream_player #(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 64,
    parameter int               AW    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] NOP   = '0,
    parameter int               CNTW  = 16
) (
    input  logic             clk,
    input  logic             asyn_n_rst,
    input  logic             ld_we,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_clear,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instruction,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count,
    output logic [CNTW-1:0]  issued,
    output logic             load_err
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_t           state;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             is_play;
    logic             load_ok;
    logic [AW:0]      count_eff;
    logic             xfer;
    logic             last;
    logic [AW-1:0]    rd_nxt;
    logic [WIDTH-1:0] first_word;

    // Decode of load acceptance, the count seen by a same-cycle start and handshake
    always_comb begin
        is_play    = (state == S_PLAY);
        load_ok    = !is_play && ld_we && !ld_clear && (count < FULL);
        count_eff  = ld_clear ? '0 : (count + {{AW{1'b0}}, load_ok});
        xfer       = instr_valid && instr_ready;
        last       = ({1'b0, rd_ptr} == (count - 1'b1));
        rd_nxt     = rd_ptr + 1'b1;
        // A start on an empty buffer with a simultaneous load must see the
        // word being written this cycle, not the stale mem[0].
        first_word = (count == '0) ? ld_data : mem[0];
    end

    assign busy = is_play;

    // Program buffer; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (load_ok) mem[count[AW-1:0]] <= ld_data;
    end

    // Control FSM with registered instruction/valid/done outputs
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state       <= S_IDLE;
            count       <= '0;
            rd_ptr      <= '0;
            instruction <= NOP;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            issued      <= '0;
            load_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (ld_clear) begin
                        count    <= '0;
                        load_err <= 1'b0;
                    end else if (ld_we) begin
                        if (load_ok) count    <= count + 1'b1;
                        else         load_err <= 1'b1;
                    end
                    if (start) begin
                        if (count_eff != '0) begin
                            state       <= S_PLAY;
                            rd_ptr      <= '0;
                            issued      <= '0;
                            instruction <= first_word;
                            instr_valid <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (ld_we) load_err <= 1'b1;
                    if (xfer && issued != CNT_MAX) issued <= issued + 1'b1;
                    if (stop) begin
                        state       <= S_IDLE;
                        instr_valid <= 1'b0;
                        instruction <= NOP;
                    end else if (xfer) begin
                        if (!last) begin
                            rd_ptr      <= rd_nxt;
                            instruction <= mem[rd_nxt];
                        end else if (loop_en) begin
                            rd_ptr      <= '0;
                            instruction <= mem[0];
                        end else begin
                            state       <= S_DONE;
                            instr_valid <= 1'b0;
                            instruction <= NOP;
                            done        <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    instr_valid <= 1'b0;
                    instruction <= NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_player.sv
// Scoreboard bench for instr_stream_player: expected words are queued as
// programs are started and popped by a monitor on every observed transfer.
module tb_instr_stream_player;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int CNTW  = 16;
    localparam logic [WIDTH-1:0] NOP = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             asyn_n_rst;
    logic             ld_we, ld_clear, start, stop, loop_en, instr_ready;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] instruction;
    logic             instr_valid, busy, done, load_err;
    logic [AW:0]      count;
    logic [CNTW-1:0]  issued;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b1;
    logic [WIDTH-1:0] exp_q [$];

    logic [WIDTH-1:0] w0 = 32'h2001_0007;
    logic [WIDTH-1:0] w1 = 32'h2022_FFF9;
    logic [WIDTH-1:0] w2 = 32'h0022_1820;

    instr_stream_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP), .CNTW(CNTW)) dut (
        .clk(clk), .asyn_n_rst(asyn_n_rst), .ld_we(ld_we), .ld_data(ld_data),
        .ld_clear(ld_clear), .start(start), .stop(stop), .loop_en(loop_en),
        .instr_ready(instr_ready), .instruction(instruction), .instr_valid(instr_valid),
        .busy(busy), .done(done), .count(count), .issued(issued), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en && asyn_n_rst && instr_valid && instr_ready) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL xfer_extra: got 0x%08h, required no transfer", instruction);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (instruction !== e) begin
                    bad = bad + 1;
                    $display("FAIL xfer_word: got 0x%08h, required 0x%08h", instruction, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] w);
        ld_we = 1'b1; ld_data = w;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic clear_buf();
        ld_clear = 1'b1;
        tick();
        ld_clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit got);
        got = 1'b0; cyc = 0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        total++; if (instruction !== NOP) begin bad++; $display("FAIL rst_instr: got 0x%08h, required 0x%08h", instruction, NOP); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b, required 0", done); end
        total++; if (count !== '0) begin bad++; $display("FAIL rst_count: got %0d, required 0", count); end
        total++; if (issued !== '0) begin bad++; $display("FAIL rst_issued: got %0d, required 0", issued); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err: got %b, required 0", load_err); end
    endtask

    task automatic test_single_pass();
        int cyc; bit got;
        clear_buf();
        load_word(w0); load_word(w1); load_word(w2);
        exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
        instr_ready = 1'b1;
        do_start();
        total++; if (instr_valid !== 1'b1 || instruction !== w0) begin bad++; $display("FAIL sp_latency: got valid=%b 0x%08h, required valid=1 0x%08h", instr_valid, instruction, w0); end
        wait_done(10, cyc, got);
        total++; if (!got || cyc != 4) begin bad++; $display("FAIL sp_done_time: got done=%b after %0d, required done after 4", got, cyc); end
        total++; if (issued !== 16'd3) begin bad++; $display("FAIL sp_issued: got %0d, required 3", issued); end
        total++; if (instruction !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL sp_idle_out: got valid=%b 0x%08h, required valid=0 NOP", instr_valid, instruction); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sp_queue: got %0d left, required 0", exp_q.size()); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL sp_done_pulse: got %b, required 0", done); end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        int cyc; bit got;
        exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
        instr_ready = 1'b1;
        do_start();
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (instr_valid !== 1'b1 || instruction !== w1) begin bad++; $display("FAIL stall_hold%0d: got valid=%b 0x%08h, required valid=1 0x%08h", i, instr_valid, instruction, w1); end
        end
        instr_ready = 1'b1;
        wait_done(10, cyc, got);
        total++; if (!got) begin bad++; $display("FAIL stall_done: got no done, required done"); end
        total++; if (issued !== 16'd3) begin bad++; $display("FAIL stall_issued: got %0d, required 3", issued); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_queue: got %0d left, required 0", exp_q.size()); end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_loop();
        int cyc; bit got;
        clear_buf();
        load_word(w0); load_word(w1);
        for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? w0 : w1);
        loop_en = 1'b1; instr_ready = 1'b1;
        do_start();
        repeat (7) tick();
        loop_en = 1'b0;
        exp_q.push_back(w1);
        wait_done(6, cyc, got);
        total++; if (!got || cyc != 2) begin bad++; $display("FAIL loop_finish: got done=%b after %0d, required done after 2", got, cyc); end
        total++; if (issued !== 16'd8) begin bad++; $display("FAIL loop_issued: got %0d, required 8", issued); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL loop_queue: got %0d left, required 0", exp_q.size()); end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_full_and_errors();
        int cyc; bit got;
        clear_buf();
        for (int i = 0; i < DEPTH; i++) load_word(32'hA500_0000 + i);
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL full_no_err: got %b, required 0", load_err); end
        load_word(32'hDEAD_BEEF);
        total++; if (count !== 7'(DEPTH) || load_err !== 1'b1) begin bad++; $display("FAIL full_overflow: got count=%0d err=%b, required count=64 err=1", count, load_err); end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'hA500_0000 + i);
        instr_ready = 1'b1;
        do_start();
        wait_done(DEPTH + 10, cyc, got);
        total++; if (!got || issued !== 16'(DEPTH)) begin bad++; $display("FAIL full_play: got done=%b issued=%0d, required done=1 issued=64", got, issued); end
        tick();
        instr_ready = 1'b0;
        clear_buf();
        total++; if (count !== '0 || load_err !== 1'b0) begin bad++; $display("FAIL clear: got count=%0d err=%b, required 0 0", count, load_err); end
        ld_clear = 1'b1; ld_we = 1'b1; ld_data = 32'h1111_1111;
        tick();
        ld_clear = 1'b0; ld_we = 1'b0;
        total++; if (count !== '0 || load_err !== 1'b0) begin bad++; $display("FAIL clear_wins: got count=%0d err=%b, required 0 0", count, load_err); end
        load_word(w0); load_word(w1);
        do_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL play_busy: got %b, required 1", busy); end
        load_word(w2);
        total++; if (load_err !== 1'b1 || count !== 7'd2) begin bad++; $display("FAIL play_load: got err=%b count=%0d, required err=1 count=2", load_err, count); end
        clear_buf();
        total++; if (count !== 7'd2 || load_err !== 1'b1) begin bad++; $display("FAIL play_clear: got count=%0d err=%b, required 2 1", count, load_err); end
        stop = 1'b1; tick(); stop = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL play_stop: got busy=%b done=%b, required 0 0", busy, done); end
    endtask

    task automatic test_stop_and_empty();
        clear_buf();
        for (int i = 0; i < 8; i++) load_word(32'h0100_0000 + i);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h0100_0000 + i);
        instr_ready = 1'b1; loop_en = 1'b1;
        do_start();
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0; instr_ready = 1'b0; loop_en = 1'b0;
        total++; if (issued !== 16'd6) begin bad++; $display("FAIL stop_issued: got %0d, required 6", issued); end
        total++; if (busy !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP || done !== 1'b0) begin bad++; $display("FAIL stop_state: got busy=%b valid=%b 0x%08h done=%b, required 0 0 NOP 0", busy, instr_valid, instruction, done); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stop_queue: got %0d left, required 0", exp_q.size()); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL stop_no_done: got %b, required 0", done); end
        clear_buf();
        do_start();
        total++; if (done !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_start: got done=%b valid=%b busy=%b, required 1 0 0", done, instr_valid, busy); end
        tick();
        total++; if (done !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL empty_after: got done=%b valid=%b, required 0 0", done, instr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] x;
        x = 32'h8C22_0004;
        loop_en = 1'b1;
        ld_we = 1'b1; ld_data = x; start = 1'b1;
        tick();
        ld_we = 1'b0; start = 1'b0;
        total++; if (instr_valid !== 1'b1 || instruction !== x || count !== 7'd1) begin bad++; $display("FAIL ld_start: got valid=%b 0x%08h count=%0d, required 1 0x%08h 1", instr_valid, instruction, count, x); end
        repeat (3) exp_q.push_back(x);
        instr_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0; loop_en = 1'b0;
        total++; if (issued !== 16'd3 || busy !== 1'b0) begin bad++; $display("FAIL single_loop: got issued=%0d busy=%b, required 3 0", issued, busy); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_play();
        mon_en = 1'b0;
        clear_buf();
        load_word(w0); load_word(w1); load_word(w2);
        loop_en = 1'b1; instr_ready = 1'b1;
        do_start();
        repeat (2) tick();
        #2;
        asyn_n_rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL arst_out: got busy=%b valid=%b 0x%08h, required 0 0 NOP", busy, instr_valid, instruction); end
        total++; if (count !== '0 || issued !== '0 || load_err !== 1'b0) begin bad++; $display("FAIL arst_regs: got count=%0d issued=%0d err=%b, required 0 0 0", count, issued, load_err); end
        #1;
        asyn_n_rst = 1'b1;
        loop_en = 1'b0; instr_ready = 1'b0;
        tick();
        do_start();
        total++; if (done !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL arst_reload: got done=%b valid=%b, required 1 0", done, instr_valid); end
        mon_en = 1'b1;
    endtask

    initial begin
        asyn_n_rst = 1'b0;
        ld_we = 1'b0; ld_data = '0; ld_clear = 1'b0; start = 1'b0;
        stop = 1'b0; loop_en = 1'b0; instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        asyn_n_rst = 1'b1;
        tick();
        test_reset();
        test_single_pass();
        test_stall();
        test_loop();
        test_full_and_errors();
        test_stop_and_empty();
        test_back_to_back();
        test_reset_mid_play();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
